// File: rtl/md_fft_pkg.sv
// md_fft_pkg
// Shared types and helpers for the FFT framing path.
//   FFT_DATA_W     : width of one real/imag sample component
//   FFT_PTS_W      : width of the FFT length field (binary N, up to 32)
//   feeder_state_t : framing FSM states
//   fft_beat_t     : one stream beat {sop, eop, re, im}
//   fft_pts_legal  : true for the FFT lengths the core is built for
package md_fft_pkg;

  localparam int FFT_DATA_W = 32;
  localparam int FFT_PTS_W  = 6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } feeder_state_t;

  typedef struct packed {
    logic                         sop;
    logic                         eop;
    logic signed [FFT_DATA_W-1:0] re;
    logic signed [FFT_DATA_W-1:0] im;
  } fft_beat_t;

  function automatic logic fft_pts_legal(input logic [FFT_PTS_W-1:0] pts);
    return (pts == FFT_PTS_W'(8)) || (pts == FFT_PTS_W'(16)) ||
           (pts == FFT_PTS_W'(32));
  endfunction

endpackage

// File: rtl/fft_skid_buf.sv
// fft_skid_buf
// Two-entry valid/ready buffer carrying fft_beat_t. The output beat comes
// straight from the head register, and in_ready depends only on the fill
// count, so there is no combinational path from out_ready to in_ready.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : upstream handshake, in_beat is the offered beat
//   out_valid/out_ready : downstream handshake, out_beat is the held beat
module fft_skid_buf
  import md_fft_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      in_valid,
  output logic      in_ready,
  input  fft_beat_t in_beat,
  output logic      out_valid,
  input  logic      out_ready,
  output fft_beat_t out_beat
);

  logic [1:0] cnt_q, cnt_d;
  fft_beat_t  head_q, head_d;
  fft_beat_t  tail_q, tail_d;
  logic       push, pop;

  assign in_ready  = (cnt_q != 2'd2);
  assign out_valid = (cnt_q != 2'd0);
  assign out_beat  = head_q;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    cnt_d  = cnt_q;
    head_d = head_q;
    tail_d = tail_q;
    case (cnt_q)
      2'd0: begin
        if (push) begin
          head_d = in_beat;
          cnt_d  = 2'd1;
        end
      end
      2'd1: begin
        // Push and pop together replace the head and keep occupancy at one.
        if (push && pop) begin
          head_d = in_beat;
        end else if (push) begin
          tail_d = in_beat;
          cnt_d  = 2'd2;
        end else if (pop) begin
          cnt_d  = 2'd0;
        end
      end
      default: begin
        // Full: in_ready is low, so only a pop can happen here.
        if (pop) begin
          head_d = tail_q;
          cnt_d  = 2'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

endmodule

// File: rtl/fft_frame_feeder.sv
// fft_frame_feeder
// Frames an unframed complex sample stream into Avalon-ST frames for the FFT
// sink port. One batch of cfg_frames frames of cfg_pts samples is produced
// per accepted start pulse; sop/eop are tagged as samples enter the skid
// buffer, and the batch ends when the final eop leaves the buffer.
//   clk, rst                 : clock, asynchronous active-high reset
//   start, cfg_pts, cfg_frames: batch request and its configuration
//   busy, done, cfg_err      : batch status
//   in_valid/in_ready, in_real/in_imag : upstream sample stream
//   sink_*                   : Avalon-ST stream to the FFT core
//   fftpts_in                : FFT length latched for the current batch
module fft_frame_feeder
  import md_fft_pkg::*;
#(
  parameter int DATA_W = FFT_DATA_W,
  parameter int PTS_W  = FFT_PTS_W,
  parameter int FRM_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [PTS_W-1:0]  cfg_pts,
  input  logic [FRM_W-1:0]  cfg_frames,
  output logic              busy,
  output logic              done,
  output logic              cfg_err,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_real,
  input  logic [DATA_W-1:0] in_imag,
  output logic              sink_valid,
  input  logic              sink_ready,
  output logic              sink_sop,
  output logic              sink_eop,
  output logic [1:0]        sink_error,
  output logic [DATA_W-1:0] sink_real,
  output logic [DATA_W-1:0] sink_imag,
  output logic [PTS_W-1:0]  fftpts_in
);

  feeder_state_t    state_q, state_d;
  logic [PTS_W-1:0] pts_q, pts_d;
  logic [FRM_W-1:0] frames_q, frames_d;
  logic [PTS_W-1:0] samp_cnt_q, samp_cnt_d;
  logic [FRM_W-1:0] frm_cnt_q, frm_cnt_d;
  logic             cfg_err_q, cfg_err_d;

  logic             feed_open;
  logic             buf_in_valid;
  logic             buf_in_ready;
  logic             accept;
  logic             last_hs;
  fft_beat_t        in_beat;
  fft_beat_t        out_beat;

  // Intake is open only in STREAM and until the final eop has been tagged;
  // frm_cnt reaches the frame count exactly when that last sample enters.
  assign feed_open    = (state_q == ST_STREAM) && (frm_cnt_q != frames_q);
  assign in_ready     = feed_open && buf_in_ready;
  assign buf_in_valid = in_valid && feed_open;
  assign accept       = in_valid && in_ready;

  assign in_beat.sop = (samp_cnt_q == '0);
  assign in_beat.eop = (samp_cnt_q == pts_q - PTS_W'(1));
  assign in_beat.re  = in_real;
  assign in_beat.im  = in_imag;

  // Frames are at least 8 long and the buffer holds 2, so once every frame
  // has been tagged the only eop still able to reach the sink is the last.
  assign last_hs = sink_valid && sink_ready && sink_eop &&
                   (frm_cnt_q == frames_q);

  always_comb begin
    state_d    = state_q;
    pts_d      = pts_q;
    frames_d   = frames_q;
    samp_cnt_d = samp_cnt_q;
    frm_cnt_d  = frm_cnt_q;
    cfg_err_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (fft_pts_legal(cfg_pts) && (cfg_frames != '0)) begin
            pts_d      = cfg_pts;
            frames_d   = cfg_frames;
            samp_cnt_d = '0;
            frm_cnt_d  = '0;
            state_d    = ST_STREAM;
          end else begin
            cfg_err_d  = 1'b1;
          end
        end
      end
      ST_STREAM: begin
        if (accept) begin
          if (in_beat.eop) begin
            samp_cnt_d = '0;
            frm_cnt_d  = frm_cnt_q + FRM_W'(1);
          end else begin
            samp_cnt_d = samp_cnt_q + PTS_W'(1);
          end
        end
        if (last_hs) begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pts_q      <= '0;
      frames_q   <= '0;
      samp_cnt_q <= '0;
      frm_cnt_q  <= '0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pts_q      <= pts_d;
      frames_q   <= frames_d;
      samp_cnt_q <= samp_cnt_d;
      frm_cnt_q  <= frm_cnt_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  fft_skid_buf u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_valid (buf_in_valid),
    .in_ready (buf_in_ready),
    .in_beat  (in_beat),
    .out_valid(sink_valid),
    .out_ready(sink_ready),
    .out_beat (out_beat)
  );

  assign sink_sop   = out_beat.sop;
  assign sink_eop   = out_beat.eop;
  assign sink_real  = out_beat.re;
  assign sink_imag  = out_beat.im;
  assign sink_error = 2'b00;
  assign fftpts_in  = pts_q;
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_fft_frame_feeder.sv
// tb_fft_frame_feeder
// Scoreboard bench: each accepted input sample is pushed with the sop/eop
// the bench expects, and popped and compared when the sink accepts a beat.
module tb_fft_frame_feeder;

  localparam int DATA_W = 32;
  localparam int PTS_W  = 6;
  localparam int FRM_W  = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [PTS_W-1:0]  cfg_pts = '0;
  logic [FRM_W-1:0]  cfg_frames = '0;
  logic              busy, done, cfg_err;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_real = '0;
  logic [DATA_W-1:0] in_imag = '0;
  logic              sink_valid;
  logic              sink_ready = 1'b0;
  logic              sink_sop, sink_eop;
  logic [1:0]        sink_error;
  logic [DATA_W-1:0] sink_real, sink_imag;
  logic [PTS_W-1:0]  fftpts_in;

  always #5 clk = ~clk;

  fft_frame_feeder #(.DATA_W(DATA_W), .PTS_W(PTS_W), .FRM_W(FRM_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cfg_pts   (cfg_pts),
    .cfg_frames(cfg_frames),
    .busy      (busy),
    .done      (done),
    .cfg_err   (cfg_err),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_real   (in_real),
    .in_imag   (in_imag),
    .sink_valid(sink_valid),
    .sink_ready(sink_ready),
    .sink_sop  (sink_sop),
    .sink_eop  (sink_eop),
    .sink_error(sink_error),
    .sink_real (sink_real),
    .sink_imag (sink_imag),
    .fftpts_in (fftpts_in)
  );

  int errors = 0;
  int checks = 0;

  logic [65:0] exp_q[$];
  int          occ;
  bit          stall_q;
  logic [65:0] hold_v;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [65:0] sink_vec();
    return {sink_sop, sink_eop, sink_real, sink_imag};
  endfunction

  // Runs one batch from the current negedge. Returns at the first IDLE
  // negedge after done, or right after beat abort_after when nonzero.
  task automatic run_batch(input int n, input int f, input bit rnd,
                           input int abort_after, input int inject_at);
    int total;
    int sent;
    int recv;
    int cyc;
    bit fin;
    bit push;
    bit pop;
    logic [65:0] e;
    total = n * f;
    sent = 0;
    recv = 0;
    cyc = 0;
    fin = 0;
    cfg_pts = PTS_W'(n);
    cfg_frames = FRM_W'(f);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_on", busy, 1);
    occ = 0;
    stall_q = 0;
    while (!fin) begin
      sink_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_real = $urandom;
      in_imag = $urandom;
      if (cyc == inject_at) begin
        start = 1'b1;
        cfg_pts = PTS_W'(16);
      end else begin
        start = 1'b0;
      end
      #1;
      if (stall_q) chk("hold", {sink_valid, sink_vec()}, {1'b1, hold_v});
      if (cyc == inject_at + 1) chk("no_cfg_err", cfg_err, 0);
      chk("in_ready", in_ready, (sent < total) ? (occ < 2) : 0);
      push = in_valid && in_ready;
      pop = sink_valid && sink_ready;
      if (push && sent < total) begin
        exp_q.push_back({(sent % n) == 0, (sent % n) == n - 1, in_real, in_imag});
        sent++;
      end
      if (pop) begin
        if (exp_q.size() == 0) begin
          chk("stray_beat", sink_valid, 0);
        end else begin
          e = exp_q.pop_front();
          chk("beat", sink_vec(), e);
          chk("fftpts", fftpts_in, n);
          recv++;
        end
      end
      occ = occ + int'(push) - int'(pop);
      stall_q = sink_valid && !sink_ready;
      hold_v = sink_vec();
      cyc++;
      if (recv == total || (abort_after > 0 && recv == abort_after)) begin
        fin = 1;
      end else if (cyc > total * 8 + 50) begin
        chk("timeout", recv, total);
        fin = 1;
      end
      @(negedge clk);
    end
    start = 1'b0;
    in_valid = 1'b0;
    if (abort_after == 0 && recv == total) begin
      chk("done_pulse", done, 1);
      chk("busy_in_done", busy, 1);
      chk("quiet_in_done", sink_valid, 0);
      @(negedge clk);
      chk("done_clear", done, 0);
      chk("busy_off", busy, 0);
      chk("quiet_idle", sink_valid, 0);
    end
  endtask

  initial begin
    #12;
    chk("rst_status", {busy, done, cfg_err, in_ready}, 4'b0000);
    chk("rst_sink_ctl", {sink_valid, sink_sop, sink_eop, sink_error}, 5'b0);
    chk("rst_sink_data", {sink_real, sink_imag}, 64'd0);
    chk("rst_fftpts", fftpts_in, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Basic framing, then a batch started on the first IDLE cycle.
    run_batch(8, 2, 1'b0, 0, -1);
    run_batch(8, 1, 1'b0, 0, -1);

    // Illegal length.
    cfg_pts = PTS_W'(12);
    cfg_frames = FRM_W'(1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("err_pts_pulse", cfg_err, 1);
    chk("err_pts_busy", busy, 0);
    @(negedge clk);
    chk("err_pts_clear", cfg_err, 0);
    chk("err_pts_idle", busy, 0);

    // Zero frames.
    cfg_pts = PTS_W'(8);
    cfg_frames = FRM_W'(0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("err_frm_pulse", cfg_err, 1);
    chk("err_frm_busy", busy, 0);
    @(negedge clk);
    chk("err_frm_clear", cfg_err, 0);

    // Backpressure with a stray start carrying a different length.
    run_batch(32, 3, 1'b1, 0, 10);

    // Reset in the middle of a frame.
    run_batch(32, 1, 1'b0, 5, -1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", sink_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", in_ready, 0);
    chk("mid_rst_pts", fftpts_in, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    occ = 0;
    stall_q = 0;
    @(negedge clk);
    run_batch(16, 1, 1'b0, 0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
